// File: rtl/bus_pkg.sv
// Shared widths, slave-index type and address-mask helper for the bus interconnect.
package bus_pkg;
    localparam int ADDR_W     = 30;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int MAX_SLAVES = 16;
    localparam int IDX_W      = 4;

    typedef logic [IDX_W-1:0] slv_idx_t;

    // Mask keeping only the address bits above the slave's decoded window.
    function automatic logic [ADDR_W-1:0] hi_mask(input int width);
        hi_mask = ~((30'h1 << width) - 30'h1);
    endfunction
endpackage

// File: rtl/bus_decode.sv
// Address decoder: one-hot slave select, hit flag and encoded index; lowest index wins on overlap.
module bus_decode
    import bus_pkg::*;
#(
    parameter int               NUM_SLAVES              = 2,
    parameter logic [ADDR_W-1:0] SLAVE_BASE [NUM_SLAVES] = '{30'h12340000, 30'h1bcd0000},
    parameter int               SLAVE_WIDTH [NUM_SLAVES] = '{4, 3}
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  hit_o,
    output slv_idx_t              idx_o
);

    // Scan from the highest index down so the lowest matching slave is the one left standing.
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (((addr_i ^ SLAVE_BASE[i]) & hi_mask(SLAVE_WIDTH[i])) == 30'h0) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
                idx_o    = slv_idx_t'(i);
            end else begin
                sel_o = sel_o;
            end
        end
    end

endmodule

// File: rtl/bus_intercon.sv
// Single-master to NUM_SLAVES-slave interconnect with one-cycle read return.
// Define BUS_INTERCON_ERR_EN to report unmapped accesses on err_o; otherwise they are dropped.
module bus_intercon
    import bus_pkg::*;
#(
    parameter int               NUM_SLAVES              = 2,
    parameter logic [ADDR_W-1:0] SLAVE_BASE [NUM_SLAVES] = '{30'h12340000, 30'h1bcd0000},
    parameter int               SLAVE_WIDTH [NUM_SLAVES] = '{4, 3}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_i,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic [MASK_W-1:0]                byte_mask_i,
    output logic [DATA_W-1:0]                data_o,
    output logic                             valid_o,
    output logic                             stall_o,
    output logic                             err_o,
    output logic [NUM_SLAVES-1:0]            sl_en_o,
    output logic                             sl_we_o,
    output logic [ADDR_W-1:0]                sl_addr_o,
    output logic [DATA_W-1:0]                sl_data_o,
    output logic [MASK_W-1:0]                sl_byte_mask_o,
    input  logic [NUM_SLAVES-1:0][DATA_W-1:0] sl_data_i,
    input  logic [NUM_SLAVES-1:0]            sl_stall_i
);

    logic [NUM_SLAVES-1:0] sel_s;
    logic                  hit_s;
    slv_idx_t              idx_s;
    logic                  accept_s;
    logic [DATA_W-1:0]     rdata_s;

    slv_idx_t idx_d,   idx_q;
    logic     we_d,    we_q;
    logic     valid_d, valid_q;
    logic     err_d,   err_q;

    bus_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_WIDTH(SLAVE_WIDTH)
    ) u_decode (
        .addr_i(addr_i),
        .sel_o (sel_s),
        .hit_o (hit_s),
        .idx_o (idx_s)
    );

    // Request routing, stall and next-state for the response registers.
    always_comb begin
        sl_en_o        = sel_s & {NUM_SLAVES{en_i}};
        sl_we_o        = we_i;
        sl_addr_o      = addr_i;
        sl_data_o      = data_i;
        sl_byte_mask_o = byte_mask_i;
        stall_o        = en_i & (|(sel_s & sl_stall_i));
        accept_s       = en_i & ~stall_o;
        valid_d        = accept_s & hit_s;
        idx_d          = accept_s ? idx_s : idx_q;
        we_d           = accept_s ? we_i : we_q;
`ifdef BUS_INTERCON_ERR_EN
        err_d          = accept_s & ~hit_s;
`else
        err_d          = 1'b0;
`endif
    end

    // Read data is steered from the slave that was accepted last cycle; zero otherwise.
    always_comb begin
        rdata_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (valid_q && !we_q && (idx_q == slv_idx_t'(i))) begin
                rdata_s = sl_data_i[i];
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    // Response-side state; reset discards any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign data_o  = rdata_s;

endmodule

// File: tb/tb_bus_intercon.sv
// Scoreboard bench for bus_intercon: driver pushes expected responses, a negedge monitor pops and compares.
module tb_bus_intercon;
    import bus_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic             we_i;
    logic [29:0]      addr_i;
    logic [31:0]      data_i;
    logic [3:0]       byte_mask_i;
    logic [31:0]      data_o;
    logic             valid_o;
    logic             stall_o;
    logic             err_o;
    logic [1:0]       sl_en_o;
    logic             sl_we_o;
    logic [29:0]      sl_addr_o;
    logic [31:0]      sl_data_o;
    logic [3:0]       sl_byte_mask_o;
    logic [1:0][31:0] sl_data_i;
    logic [1:0]       sl_stall_i;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [8];
    logic [31:0] rd0 = 32'h0;
    logic [31:0] rd1 = 32'h0;

    rsp_t q[$];
    int   checks = 0;
    int   errors = 0;

    bus_intercon dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .byte_mask_i   (byte_mask_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .stall_o       (stall_o),
        .err_o         (err_o),
        .sl_en_o       (sl_en_o),
        .sl_we_o       (sl_we_o),
        .sl_addr_o     (sl_addr_o),
        .sl_data_o     (sl_data_o),
        .sl_byte_mask_o(sl_byte_mask_o),
        .sl_data_i     (sl_data_i),
        .sl_stall_i    (sl_stall_i)
    );

    always #5 clk = ~clk;

    assign sl_data_i = {rd1, rd0};

    // Behavioural slaves: byte-masked write, registered one-cycle read.
    always @(posedge clk) begin
        if (sl_en_o[0] && !sl_stall_i[0]) begin
            if (sl_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sl_byte_mask_o[b]) mem0[sl_addr_o[3:0]][8*b +: 8] <= sl_data_o[8*b +: 8];
            end else begin
                rd0 <= mem0[sl_addr_o[3:0]];
            end
        end
        if (sl_en_o[1] && !sl_stall_i[1]) begin
            if (sl_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sl_byte_mask_o[b]) mem1[sl_addr_o[2:0]][8*b +: 8] <= sl_data_o[8*b +: 8];
            end else begin
                rd1 <= mem1[sl_addr_o[2:0]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest expected entry; idle cycles show zero data.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_o || err_o) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got valid=%b err=%b data=%h expected no response",
                                 valid_o, err_o, data_o);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_valid", {31'h0, valid_o}, {31'h0, e.valid});
                        chk("rsp_err",   {31'h0, err_o},   {31'h0, e.err});
                        chk("rsp_data",  data_o, e.data);
                    end
                end else begin
                    chk("idle_data", data_o, 32'h0);
                end
            end
        end
    end

    // Present one request (optionally stalled on slave 0), check the request side, push the expected response.
    task automatic issue(input logic we, input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic [1:0] exp_sel, input logic [31:0] exp_rd, input int stall_cyc,
                         input bit push);
        rsp_t r;
        en_i = 1'b1; we_i = we; addr_i = a; data_i = d; byte_mask_i = m;
        for (int c = 0; c < stall_cyc; c++) begin
            sl_stall_i = 2'b01;
            #1;
            chk("stall_hi", {31'h0, stall_o}, 32'h1);
            @(posedge clk);
            #1;
        end
        sl_stall_i = 2'b00;
        #1;
        chk("sl_en",    {30'h0, sl_en_o}, {30'h0, exp_sel});
        chk("stall_lo", {31'h0, stall_o}, 32'h0);
        chk("sl_addr",  {2'b00, sl_addr_o}, {2'b00, a});
        chk("sl_pass",  {sl_byte_mask_o, 27'h0, sl_we_o}, {m, 27'h0, we});
        chk("sl_data",  sl_data_o, d);
        @(posedge clk);
        if (push) begin
            if (exp_sel != 2'b00) begin
                r = '{valid: 1'b1, err: 1'b0, data: (we ? 32'h0 : exp_rd)};
                q.push_back(r);
            end else begin
`ifdef BUS_INTERCON_ERR_EN
                r = '{valid: 1'b0, err: 1'b1, data: 32'h0};
                q.push_back(r);
`endif
            end
        end
        #1;
        en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = 30'h0; data_i = 32'h0;
        byte_mask_i = 4'h0; sl_stall_i = 2'b00;
        #2;
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_err",   {31'h0, err_o},   32'h0);
        chk("rst_data",  data_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Writes to both slaves, back to back.
        issue(1'b1, 30'h12340000, 32'hdeadbeef, 4'hf, 2'b01, 32'h0, 0, 1'b1);
        issue(1'b1, 30'h12340001, 32'h12345678, 4'hf, 2'b01, 32'h0, 0, 1'b1);
        issue(1'b1, 30'h1bcd0000, 32'h87654321, 4'hf, 2'b10, 32'h0, 0, 1'b1);
        issue(1'b1, 30'h1bcd0001, 32'habcd1234, 4'hf, 2'b10, 32'h0, 0, 1'b1);
        issue(1'b1, 30'h12340002, 32'h11223344, 4'hf, 2'b01, 32'h0, 0, 1'b1);
        issue(1'b1, 30'h12340002, 32'haabbccdd, 4'h5, 2'b01, 32'h0, 0, 1'b1);

        // Back-to-back reads across both slaves, including the byte-masked word.
        issue(1'b0, 30'h12340000, 32'h0, 4'hf, 2'b01, 32'hdeadbeef, 0, 1'b1);
        issue(1'b0, 30'h12340001, 32'h0, 4'hf, 2'b01, 32'h12345678, 0, 1'b1);
        issue(1'b0, 30'h1bcd0000, 32'h0, 4'hf, 2'b10, 32'h87654321, 0, 1'b1);
        issue(1'b0, 30'h1bcd0001, 32'h0, 4'hf, 2'b10, 32'habcd1234, 0, 1'b1);
        issue(1'b0, 30'h12340002, 32'h0, 4'hf, 2'b01, 32'h11bb33dd, 0, 1'b1);

        // Unmapped read, then a window-edge miss just past slave 1's 8-word range.
        issue(1'b0, 30'h00000005, 32'h0, 4'hf, 2'b00, 32'h0, 0, 1'b1);
        issue(1'b0, 30'h1bcd0008, 32'h0, 4'hf, 2'b00, 32'h0, 0, 1'b1);
        @(posedge clk); #1;

        // Stalled read on slave 0 for two cycles.
        issue(1'b0, 30'h12340000, 32'h0, 4'hf, 2'b01, 32'hdeadbeef, 2, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset lands just after a read is accepted: no response may ever appear for it.
        issue(1'b0, 30'h1bcd0000, 32'h0, 4'hf, 2'b10, 32'h0, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_inflight_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_inflight_data",  data_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b0, 30'h12340001, 32'h0, 4'hf, 2'b01, 32'h12345678, 0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
